// File: rtl/matrix_entry_loader_if.sv
// Handshake/bus bundle between the matrix entry loader, its pulse sources and the compute engine.
// The slave modport belongs to the loader; the master modport belongs to whatever drives it.
interface matrix_entry_loader_if #(
  parameter int N = 3,
  parameter int W = 8
);
  localparam int IW = ($clog2(N) < 1) ? 1 : $clog2(N);

  logic [W-1:0]  Sw;
  logic          Load_Pulse;
  logic          Skip_Pulse;
  logic          Clear_Pulse;
  logic          Start_Pulse;
  logic          Ack_Pulse;
  logic          Eng_Done;
  logic [IW-1:0] Rd_Row;
  logic [IW-1:0] Rd_Col;
  logic [W-1:0]  Rd_Data;
  logic          Go;
  logic [IW-1:0] Cur_Row;
  logic [IW-1:0] Cur_Col;
  logic [W-1:0]  Cur_Data;
  logic          Full;
  logic          q_Load;
  logic          q_Run;
  logic          q_Done;

  modport slave (
    input  Sw, Load_Pulse, Skip_Pulse, Clear_Pulse, Start_Pulse, Ack_Pulse, Eng_Done,
    input  Rd_Row, Rd_Col,
    output Rd_Data, Go, Cur_Row, Cur_Col, Cur_Data, Full, q_Load, q_Run, q_Done
  );

  modport master (
    output Sw, Load_Pulse, Skip_Pulse, Clear_Pulse, Start_Pulse, Ack_Pulse, Eng_Done,
    output Rd_Row, Rd_Col,
    input  Rd_Data, Go, Cur_Row, Cur_Col, Cur_Data, Full, q_Load, q_Run, q_Done
  );
endinterface

// File: rtl/matrix_entry_loader.sv
// N x N matrix store filled through a row-major cursor, with a LOAD/RUN/DONE run controller
// that freezes the matrix while the engine runs and a registered engine read port.
module matrix_entry_loader #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  matrix_entry_loader_if.slave   bus
);
  localparam int              IW   = ($clog2(N) < 1) ? 1 : $clog2(N);
  localparam logic [IW-1:0]   LAST = IW'(N - 1);
  localparam logic [IW:0]     NLIM = (IW + 1)'(N);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_row, r_col, w_row_nxt, w_col_nxt;
  logic                  r_full, w_full_nxt;
  logic                  r_go, w_go_nxt;
  logic                  w_write, w_clear, w_rd_ok;
  logic signed [W-1:0]   r_mem [N][N];
  logic signed [W-1:0]   r_rd;

  function automatic logic signed [W-1:0] f_ident(input int i, input int j);
    return (i == j) ? W'(1) : '0;
  endfunction

  // Next-state / control decode; pulse priority in LOAD is Clear > Start > Load > Skip
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_full_nxt  = r_full;
    w_go_nxt    = 1'b0;
    w_write     = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        if (bus.Clear_Pulse) begin
          w_clear    = 1'b1;
          w_row_nxt  = '0;
          w_col_nxt  = '0;
          w_full_nxt = 1'b0;
        end else if (bus.Start_Pulse) begin
          if (r_full) begin
            w_state_nxt = S_RUN;
            w_go_nxt    = 1'b1;
          end
        end else if (bus.Load_Pulse || bus.Skip_Pulse) begin
          w_write = bus.Load_Pulse;
          if (r_col == LAST) begin
            w_col_nxt = '0;
            if (r_row == LAST) begin
              w_row_nxt  = '0;
              w_full_nxt = 1'b1;
            end else begin
              w_row_nxt = r_row + 1'b1;
            end
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bus.Eng_Done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.Ack_Pulse) begin
          w_state_nxt = S_LOAD;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_LOAD;
      r_row   <= '0;
      r_col   <= '0;
      r_full  <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_full  <= w_full_nxt;
      r_go    <= w_go_nxt;
    end
  end

  // Storage resets to identity so an untouched matrix is a valid operand
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          r_mem[i][j] <= f_ident(i, j);
    end else if (w_clear) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          r_mem[i][j] <= f_ident(i, j);
    end else if (w_write) begin
      r_mem[r_row][r_col] <= bus.Sw;
    end
  end

  assign w_rd_ok = ({1'b0, bus.Rd_Row} < NLIM) && ({1'b0, bus.Rd_Col} < NLIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd <= '0;
    else          r_rd <= w_rd_ok ? r_mem[bus.Rd_Row][bus.Rd_Col] : '0;
  end

  assign bus.Rd_Data  = r_rd;
  assign bus.Go       = r_go;
  assign bus.Cur_Row  = r_row;
  assign bus.Cur_Col  = r_col;
  assign bus.Cur_Data = r_mem[r_row][r_col];
  assign bus.Full     = r_full;
  assign bus.q_Load   = (r_state == S_LOAD);
  assign bus.q_Run    = (r_state == S_RUN);
  assign bus.q_Done   = (r_state == S_DONE);
endmodule
